// File: rtl/jump_resolve_if.sv
// jump_resolve_if
//   Bundle between the ID/EX/MEM pipeline and the jump resolver.
//   The pipeline side uses the master modport and drives the ID-stage
//   prediction, the MEM-stage outcome and the stall. The resolver uses the
//   slave modport and returns the redirect, the training packet and the
//   sticky protocol error.
//
//   ID side  : jump_inst, pred_taken, pred_adr, pcinc_id
//   MEM side : jump, ALUres_mem
//   control  : stall
//   results  : redirect, redirect_pc, upd_valid, upd_idx, upd_kind,
//              upd_target, protocol_err
interface jump_resolve_if #(
    parameter int IDX_W = 6
);
    logic              stall;
    logic [2:0]        jump_inst;
    logic              pred_taken;
    logic [15:0]       pred_adr;
    logic [15:0]       pcinc_id;
    logic              jump;
    logic [15:0]       ALUres_mem;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic [1:0]        upd_kind;
    logic [15:0]       upd_target;
    logic              protocol_err;

    modport master (
        output stall, jump_inst, pred_taken, pred_adr, pcinc_id, jump, ALUres_mem,
        input  redirect, redirect_pc, upd_valid, upd_idx, upd_kind, upd_target,
               protocol_err
    );

    modport slave (
        input  stall, jump_inst, pred_taken, pred_adr, pcinc_id, jump, ALUres_mem,
        output redirect, redirect_pc, upd_valid, upd_idx, upd_kind, upd_target,
               protocol_err
    );
endinterface

// File: rtl/jump_resolve.sv
// jump_resolve
//   Carries each ID-stage jump prediction down a DEPTH-entry queue to MEM,
//   compares it with the actual outcome there, and issues a registered
//   redirect to fetch plus a registered training packet to the predictor.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      jump_resolve_if.slave (ID/MEM inputs, redirect/training outputs)
//   Optional (JUMP_RESOLVE_PERF_EN defined):
//     perf_jumps  saturating count of evaluations of a valid MEM entry
//     perf_miss   saturating count of registered redirects
//
//   upd_kind encoding: 0 HIT, 1 MISS_NT, 2 ADR_MISS, 3 MISS_T.
module jump_resolve #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    jump_resolve_if.slave     bus
`ifdef JUMP_RESOLVE_PERF_EN
    ,
    output logic [15:0]       perf_jumps,
    output logic [15:0]       perf_miss
`endif
);

    localparam logic [1:0] KIND_HIT      = 2'd0;
    localparam logic [1:0] KIND_MISS_NT  = 2'd1;
    localparam logic [1:0] KIND_ADR_MISS = 2'd2;
    localparam logic [1:0] KIND_MISS_T   = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [15:0] adr;
        logic [15:0] pcinc;
    } entry_t;

    // Entry 0 is the ID capture slot, entry DEPTH-1 is the MEM entry.
    entry_t [DEPTH-1:0] q_q, q_d;
    entry_t             mem_e;

    logic              redirect_q, redirect_d;
    logic [15:0]       redirect_pc_q, redirect_pc_d;
    logic              upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;
    logic [1:0]        upd_kind_q, upd_kind_d;
    logic [15:0]       upd_target_q, upd_target_d;
    logic              perr_q, perr_d;
    logic              eval;

    always_comb begin
        q_d           = q_q;
        mem_e         = q_q[DEPTH-1];
        eval          = !bus.stall && mem_e.valid;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        upd_valid_d   = 1'b0;
        upd_idx_d     = upd_idx_q;
        upd_kind_d    = upd_kind_q;
        upd_target_d  = upd_target_q;
        // A MEM-stage jump with nothing tracked means the pipeline and the
        // queue have lost step; record it permanently.
        perr_d        = perr_q | (!bus.stall && bus.jump && !mem_e.valid);

        if (eval) begin
            case ({mem_e.pred, bus.jump})
                2'b01: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = bus.ALUres_mem;
                    upd_valid_d   = 1'b1;
                    upd_kind_d    = KIND_MISS_NT;
                end
                2'b11: begin
                    upd_valid_d = 1'b1;
                    if (bus.ALUres_mem == mem_e.adr) begin
                        upd_kind_d = KIND_HIT;
                    end else begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = bus.ALUres_mem;
                        upd_kind_d    = KIND_ADR_MISS;
                    end
                end
                2'b10: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = mem_e.pcinc;
                    upd_valid_d   = 1'b1;
                    upd_kind_d    = KIND_MISS_T;
                end
                default: ;
            endcase
        end

        if (upd_valid_d) begin
            upd_idx_d    = mem_e.pcinc[IDX_W-1:0];
            upd_target_d = bus.ALUres_mem;
        end

        if (!bus.stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                q_d[i] = q_q[i-1];
            end
            // The cycle the redirect is visible, ID holds a wrong-path
            // instruction, so it is not captured.
            q_d[0].valid = (bus.jump_inst != 3'd0) && !redirect_q;
            q_d[0].pred  = bus.pred_taken;
            q_d[0].adr   = bus.pred_adr;
            q_d[0].pcinc = bus.pcinc_id;
        end

        // Squash everything younger than the mispredicted jump, including
        // whatever is entering from ID on this edge.
        if (redirect_d) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q           <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_idx_q     <= '0;
            upd_kind_q    <= '0;
            upd_target_q  <= '0;
            perr_q        <= 1'b0;
        end else begin
            q_q           <= q_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_idx_q     <= upd_idx_d;
            upd_kind_q    <= upd_kind_d;
            upd_target_q  <= upd_target_d;
            perr_q        <= perr_d;
        end
    end

    assign bus.redirect     = redirect_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.upd_valid    = upd_valid_q;
    assign bus.upd_idx      = upd_idx_q;
    assign bus.upd_kind     = upd_kind_q;
    assign bus.upd_target   = upd_target_q;
    assign bus.protocol_err = perr_q;

`ifdef JUMP_RESOLVE_PERF_EN
    logic [15:0] perf_jumps_q, perf_jumps_d;
    logic [15:0] perf_miss_q, perf_miss_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_jumps_d = perf_jumps_q;
        perf_miss_d  = perf_miss_q;
        if (eval && perf_jumps_q != 16'hFFFF) begin
            perf_jumps_d = perf_jumps_q + 16'd1;
        end
        if (redirect_d && perf_miss_q != 16'hFFFF) begin
            perf_miss_d = perf_miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_jumps_q <= '0;
            perf_miss_q  <= '0;
        end else begin
            perf_jumps_q <= perf_jumps_d;
            perf_miss_q  <= perf_miss_d;
        end
    end

    assign perf_jumps = perf_jumps_q;
    assign perf_miss  = perf_miss_q;
`endif

endmodule

// File: tb/tb_jump_resolve.sv
// tb_jump_resolve
//   Directed bench for jump_resolve (DEPTH=2, IDX_W=6). Inputs change 1ns
//   after each rising edge; registered outputs are sampled at that point.
module tb_jump_resolve;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    jump_resolve_if #(.IDX_W(6)) bus ();

`ifdef JUMP_RESOLVE_PERF_EN
    logic [15:0] perf_jumps, perf_miss;
`endif

    jump_resolve #(.DEPTH(2), .IDX_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef JUMP_RESOLVE_PERF_EN
        ,
        .perf_jumps (perf_jumps),
        .perf_miss  (perf_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one jump at ID for a single cycle.
    task automatic issue(input logic pred, input logic [15:0] adr, input logic [15:0] pc);
        bus.jump_inst  = 3'd1;
        bus.pred_taken = pred;
        bus.pred_adr   = adr;
        bus.pcinc_id   = pc;
        tick();
        bus.jump_inst  = 3'd0;
        bus.pred_taken = 1'b0;
    endtask

    // Present the MEM outcome for a single cycle; returns 1ns after the
    // edge that registers the result.
    task automatic resolve(input logic j, input logic [15:0] alu);
        bus.jump       = j;
        bus.ALUres_mem = alu;
        tick();
        bus.jump       = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".redirect"}, 32'(bus.redirect), 32'd0);
        chk({tag, ".upd_valid"}, 32'(bus.upd_valid), 32'd0);
    endtask

    initial begin
        bus.stall      = 1'b0;
        bus.jump_inst  = 3'd0;
        bus.pred_taken = 1'b0;
        bus.pred_adr   = 16'h0;
        bus.pcinc_id   = 16'h0;
        bus.jump       = 1'b0;
        bus.ALUres_mem = 16'h0;

        #12;
        chk("rst.redirect", 32'(bus.redirect), 32'd0);
        chk("rst.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst.redirect_pc", 32'(bus.redirect_pc), 32'd0);
        chk("rst.perr", 32'(bus.protocol_err), 32'd0);
`ifdef JUMP_RESOLVE_PERF_EN
        chk("rst.perf_jumps", 32'(perf_jumps), 32'd0);
        chk("rst.perf_miss", 32'(perf_miss), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Not-taken miss
        issue(1'b0, 16'h0000, 16'h0011);
        tick();
        resolve(1'b1, 16'h0040);
        chk("nt.redirect", 32'(bus.redirect), 32'd1);
        chk("nt.redirect_pc", 32'(bus.redirect_pc), 32'h0040);
        chk("nt.upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("nt.upd_kind", 32'(bus.upd_kind), 32'd1);
        chk("nt.upd_idx", 32'(bus.upd_idx), 32'h11);
        chk("nt.upd_target", 32'(bus.upd_target), 32'h0040);
        tick();
        chk_quiet("nt.after");

        // Correct hit
        issue(1'b1, 16'h0040, 16'h0005);
        tick();
        resolve(1'b1, 16'h0040);
        chk("hit.redirect", 32'(bus.redirect), 32'd0);
        chk("hit.upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("hit.upd_kind", 32'(bus.upd_kind), 32'd0);
        chk("hit.upd_idx", 32'(bus.upd_idx), 32'h05);
        tick();
        chk_quiet("hit.after");

        // Address miss; the following jump is squashed, and the jump offered
        // at ID during the redirect cycle is ignored. Both would otherwise
        // resolve as MISS_T because jump stays 0.
        issue(1'b1, 16'h0040, 16'h0012);
        issue(1'b1, 16'h0099, 16'h0044);
        resolve(1'b1, 16'h0050);
        chk("adr.redirect", 32'(bus.redirect), 32'd1);
        chk("adr.redirect_pc", 32'(bus.redirect_pc), 32'h0050);
        chk("adr.upd_kind", 32'(bus.upd_kind), 32'd2);
        chk("adr.upd_idx", 32'(bus.upd_idx), 32'h12);
        issue(1'b1, 16'h00AA, 16'h0055);
        chk_quiet("sq.c1");
        tick();
        chk_quiet("sq.c2");
        tick();
        chk_quiet("sq.c3");
        tick();
        chk_quiet("sq.c4");

        // Taken miss: refetch from the jump's own pcinc
        issue(1'b1, 16'h0070, 16'h0023);
        tick();
        resolve(1'b0, 16'h1234);
        chk("t.redirect", 32'(bus.redirect), 32'd1);
        chk("t.redirect_pc", 32'(bus.redirect_pc), 32'h0023);
        chk("t.upd_kind", 32'(bus.upd_kind), 32'd3);
        chk("t.upd_idx", 32'(bus.upd_idx), 32'h23);
        chk("t.upd_target", 32'(bus.upd_target), 32'h1234);
        tick();
        tick();

        // Stall holding a valid MEM entry
        issue(1'b0, 16'h0000, 16'h0015);
        tick();
        bus.stall      = 1'b1;
        bus.jump       = 1'b1;
        bus.ALUres_mem = 16'h0060;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("stall.hold");
        end
        bus.stall = 1'b0;
        tick();
        bus.jump = 1'b0;
        chk("stall.redirect", 32'(bus.redirect), 32'd1);
        chk("stall.redirect_pc", 32'(bus.redirect_pc), 32'h0060);
        chk("stall.upd_kind", 32'(bus.upd_kind), 32'd1);
        chk("stall.upd_idx", 32'(bus.upd_idx), 32'h15);
        chk("stall.perr", 32'(bus.protocol_err), 32'd0);
        tick();
        chk_quiet("stall.after");

        // Jump with an empty queue
        resolve(1'b1, 16'h0077);
        chk("perr.set", 32'(bus.protocol_err), 32'd1);
        chk_quiet("perr.noact");
        tick();
        tick();
        chk("perr.sticky", 32'(bus.protocol_err), 32'd1);

        // Async reset in the middle of a redirect pulse
        issue(1'b0, 16'h0000, 16'h0021);
        tick();
        resolve(1'b1, 16'h0077);
        chk("ar.pre", 32'(bus.redirect), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar.redirect", 32'(bus.redirect), 32'd0);
        chk("ar.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("ar.redirect_pc", 32'(bus.redirect_pc), 32'd0);
        chk("ar.upd_idx", 32'(bus.upd_idx), 32'd0);
        chk("ar.upd_kind", 32'(bus.upd_kind), 32'd0);
        chk("ar.upd_target", 32'(bus.upd_target), 32'd0);
        chk("ar.perr", 32'(bus.protocol_err), 32'd0);
        #1 reset_n = 1'b1;
        tick();

        // An entry captured just before reset must not survive it
        issue(1'b1, 16'h0080, 16'h0030);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("ar.empty");
        end

`ifdef JUMP_RESOLVE_PERF_EN
        for (int i = 0; i < 70000; i++) begin
            issue(1'b0, 16'h0000, 16'h0001);
            tick();
            resolve(1'b1, 16'h0040);
            tick();
        end
        chk("perf.miss_sat", 32'(perf_miss), 32'hFFFF);
        chk("perf.jumps_sat", 32'(perf_jumps), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jump_resolve.md
Name: jump_resolve

Overview:
- Counterpart of the ID-stage jump predictor. Carries each ID-stage prediction down the pipeline to MEM and compares it with the real outcome (jump, ALUres_mem).
- Issues a registered redirect/flush to fetch and a registered training packet back to the predictor tables.
- Sits between the ID/EX/MEM pipeline registers and the fetch PC mux.

Parameters:
- DEPTH, 2, number of pipeline stages from ID capture to MEM evaluation (entries tracked = DEPTH)
- IDX_W, 6, predictor table index width (low bits of pcinc)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline hold; freezes tracking queue and suppresses evaluation
- jump_inst  in  3  ID-stage jump opcode class; nonzero = jump/branch instruction
- pred_taken  in  1  predictor asserted a taken prediction for the ID instruction
- pred_adr  in  16  predicted target for the ID instruction
- pcinc_id  in  16  PC+1 of the ID instruction
- jump  in  1  MEM-stage actual taken
- ALUres_mem  in  16  MEM-stage actual target
- redirect  out  1  one-cycle flush/refetch pulse
- redirect_pc  out  16  fetch address when redirect=1
- upd_valid  out  1  one-cycle training pulse
- upd_idx  out  IDX_W  table index = pcinc[IDX_W-1:0] of the resolved jump
- upd_kind  out  2  0=HIT, 1=MISS_NT (predicted not-taken, was taken), 2=ADR_MISS, 3=MISS_T (predicted taken, not taken)
- upd_target  out  16  ALUres_mem of the resolved jump
- protocol_err  out  1  sticky: jump=1 seen with no valid MEM entry

Behaviour:
- Queue: DEPTH entries {valid, pred, pred_adr, pcinc}. Entry 0 is written from ID and entry DEPTH-1 is the MEM entry.
  - When stall=0 the queue shifts one place per cycle. Entry 0 valid = (jump_inst != 0).
  - When stall=1 all entries hold.
- Evaluation happens when stall=0 and the MEM entry is valid:
  - pred=0, jump=1: redirect to ALUres_mem, kind MISS_NT.
  - pred=1, jump=1, ALUres_mem==pred_adr: no redirect, kind HIT.
  - pred=1, jump=1, mismatch: redirect to ALUres_mem, kind ADR_MISS.
  - pred=1, jump=0: redirect to MEM-entry pcinc, kind MISS_T.
  - pred=0, jump=0: no redirect, no update.
- Latency: redirect, redirect_pc, upd_* are registered and appear the cycle after evaluation. Pulses last exactly one cycle.
- Squash: on the same edge that registers a redirect, all younger queue entries (including the one shifting in from ID) are cleared to invalid.
- While redirect is high, the ID input is ignored. The next capture is the cycle after.
- stall=1 with a valid MEM entry: no evaluation and no pulses. Evaluation occurs on the first cycle with stall=0.
- jump=1 with the MEM entry invalid and stall=0: no action, and protocol_err is set. protocol_err clears only on reset.
- Reset (async, any time including mid-pulse):
  - all entries invalid
  - redirect=0, upd_valid=0, redirect_pc=0, upd_idx=0, upd_kind=0, upd_target=0, protocol_err=0
  - outputs drop immediately on reset_n low.
- 16-bit compare is exact. No arithmetic on addresses.

Optional Feature:
- Macro JUMP_RESOLVE_PERF_EN.
- Defined: adds outputs perf_jumps[15:0] and perf_miss[15:0], reset to 0.
  - perf_jumps increments on every evaluation with a valid MEM entry.
  - perf_miss increments on every registered redirect.
  - Both saturate at 16'hFFFF and hold.
- Undefined: ports and counters absent. All other behaviour is identical.

Test Plan:
- Not-taken miss: jump_inst=1, pred_taken=0, pcinc_id=16'h0011. Two cycles later, at MEM, jump=1 and ALUres_mem=16'h0040. Required: next cycle redirect=1, redirect_pc=16'h0040, upd_kind=1, upd_idx=6'h11.
- Correct hit: pred_taken=1, pred_adr=16'h0040. At MEM, jump=1 and ALUres_mem=16'h0040. Required: redirect stays 0; upd_valid=1, upd_kind=0.
- Address miss and squash: pred_taken=1, pred_adr=16'h0040, actual 16'h0050, with a second jump issued in the following cycle. Required: redirect_pc=16'h0050, upd_kind=2, and the second jump never produces upd_valid.
- Taken miss: pred_taken=1, pcinc_id=16'h0023, jump=0 at MEM. Required: redirect_pc=16'h0023, upd_kind=3.
- Stall: hold stall=1 for 3 cycles while the MEM entry is valid. Required: no pulses during the stall; the pulse appears the cycle after stall drops. Then jump=1 with an empty queue: protocol_err=1 and it stays set.
- Async reset: assert reset_n=0 mid-redirect pulse. Required: all outputs 0 immediately; after release the queue is empty. With the feature enabled, 70000 misses: perf_miss=16'hFFFF.
